// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  // Bit counter width: $clog2(width), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell of serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: LSB-first, one full-adder evaluation per clock,
// carry held in a flop between bits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sa_state_t        state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum, fa_carry;
  logic             last_bit;

  fa_cell u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // Shift the new sum bit in at the MSB; written as a truncated shift so it
  // also holds for WIDTH == 1.
  assign sum_nxt  = WIDTH'({fa_sum, sum_sh} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_carry;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum_out   <= sum_nxt;
            carry_out <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
